// File: rtl/vending_fsm_param.sv
// Parametrised vending-machine controller: multi-coin credit, per-item prices and stock, change return.
// Optional VEND_TIMEOUT_EN adds an inactivity timeout in CREDIT that behaves like cancel.
module vending_fsm_param #(
    parameter int unsigned NUM_ITEMS  = 3,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned MAX_CREDIT = 7,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = 12'h321,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 5
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_in,
    input  logic                cancel,
    input  logic [SEL_W-1:0]    selection,
    input  logic                restock,
    output logic [SEL_W-1:0]    drink_out,
    output logic [CREDIT_W-1:0] refund,
    output logic [1:0]          cur_state,
    output logic [CREDIT_W-1:0] credit,
    output logic                sold_out,
    output logic                insufficient,
    output logic                coin_reject
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } state_t;

    state_t               state;
    logic                 coin_q;
    logic [STOCK_W-1:0]   stock [NUM_ITEMS];
    logic                 coin_rise;
    logic                 sel_valid;
    logic [CREDIT_W-1:0]  sel_price;
    logic [STOCK_W-1:0]   sel_stock;
    logic                 timeout;

    assign coin_rise = coin_in & ~coin_q;
    assign cur_state = state;

    // Decode the requested item's price and remaining stock; out-of-range codes stay invalid.
    always_comb begin
        sel_valid = 1'b0;
        sel_price = '0;
        sel_stock = '0;
        for (int unsigned i = 1; i <= NUM_ITEMS; i++) begin
            if (selection == SEL_W'(i)) begin
                sel_valid = 1'b1;
                sel_price = PRICES[(i-1)*CREDIT_W +: CREDIT_W];
                sel_stock = stock[i-1];
            end
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] idle_cnt;

    assign timeout = (32'(idle_cnt) == TIMEOUT_CYCLES);

    // Held at zero outside CREDIT, so entering CREDIT always starts a fresh count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (state != CREDIT || coin_rise || selection != '0) begin
            idle_cnt <= '0;
        end else if (!timeout) begin
            idle_cnt <= idle_cnt + TMO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            credit       <= '0;
            coin_q       <= 1'b0;
            drink_out    <= '0;
            refund       <= '0;
            sold_out     <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= 1'b0;
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            coin_q       <= coin_in;
            drink_out    <= '0;
            refund       <= '0;
            sold_out     <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= 1'b0;
            case (state)
                IDLE: begin
                    if (restock) begin
                        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                            stock[i] <= STOCK_W'(STOCK_INIT);
                        end
                    end
                    if (coin_rise) begin
                        credit <= CREDIT_W'(1);
                        state  <= CREDIT;
                    end
                end
                CREDIT: begin
                    if (cancel || timeout) begin
                        refund      <= credit;
                        credit      <= '0;
                        coin_reject <= coin_rise;
                        state       <= REFUND;
                    end else if (sel_valid && sel_stock != '0 && credit >= sel_price) begin
                        drink_out   <= selection;
                        refund      <= credit - sel_price;
                        credit      <= '0;
                        coin_reject <= coin_rise;
                        state       <= VEND;
                        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                            if (selection == SEL_W'(i + 1)) begin
                                stock[i] <= stock[i] - STOCK_W'(1);
                            end
                        end
                    end else begin
                        // Refused or ignored selection still lets a concurrent coin through.
                        if (sel_valid) begin
                            if (sel_stock == '0) begin
                                sold_out <= 1'b1;
                            end else begin
                                insufficient <= 1'b1;
                            end
                        end
                        if (coin_rise) begin
                            if (credit == CREDIT_W'(MAX_CREDIT)) begin
                                coin_reject <= 1'b1;
                            end else begin
                                credit <= credit + CREDIT_W'(1);
                            end
                        end
                    end
                end
                VEND, REFUND: begin
                    coin_reject <= coin_rise;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_fsm_param.sv
// Self-checking bench for vending_fsm_param: directed scenarios plus randomized traffic
// compared against a transaction-level model of credit, stock and change.
module tb_vending_fsm_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_in = 1'b0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [1:0] selection = 2'd0;
    logic [1:0] drink_out;
    logic [3:0] refund;
    logic [1:0] cur_state;
    logic [3:0] credit;
    logic       sold_out;
    logic       insufficient;
    logic       coin_reject;

    vending_fsm_param dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .cancel(cancel),
        .selection(selection), .restock(restock), .drink_out(drink_out),
        .refund(refund), .cur_state(cur_state), .credit(credit),
        .sold_out(sold_out), .insufficient(insufficient), .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: water=1, coke=2, juice=3 coins; 5 of each on reset/restock; credit caps at 7.
    int price_tbl [1:3] = '{1, 2, 3};
    int m_stock   [1:3];
    int m_phase, m_credit, m_prev_coin;
    int e_drink, e_refund, e_sold, e_insuf, e_rej;

    task automatic model_reset();
        m_phase = 0; m_credit = 0; m_prev_coin = 0;
        for (int i = 1; i <= 3; i++) m_stock[i] = 5;
        e_drink = 0; e_refund = 0; e_sold = 0; e_insuf = 0; e_rej = 0;
    endtask

    task automatic model_step(input int c, input int cn, input int s, input int rs);
        bit rise;
        bit item_ok;
        rise = (c != 0) && (m_prev_coin == 0);
        m_prev_coin = c;
        item_ok = (s >= 1 && s <= 3);
        e_drink = 0; e_refund = 0; e_sold = 0; e_insuf = 0; e_rej = 0;
        if (m_phase == 0) begin
            if (rs != 0) for (int i = 1; i <= 3; i++) m_stock[i] = 5;
            if (rise) begin m_credit = 1; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (cn != 0) begin
                e_refund = m_credit; m_credit = 0; m_phase = 3; e_rej = rise;
            end else if (item_ok && m_stock[s] > 0 && m_credit >= price_tbl[s]) begin
                e_drink = s; e_refund = m_credit - price_tbl[s];
                m_credit = 0; m_stock[s] -= 1; m_phase = 2; e_rej = rise;
            end else begin
                if (item_ok) begin
                    if (m_stock[s] == 0) e_sold = 1; else e_insuf = 1;
                end
                if (rise) begin
                    if (m_credit == 7) e_rej = 1; else m_credit += 1;
                end
            end
        end else begin
            m_phase = 0; e_rej = rise;
        end
    endtask

    task automatic cyc(input int c, input int cn, input int s, input int rs);
        coin_in = (c != 0); cancel = (cn != 0); selection = 2'(s); restock = (rs != 0);
        model_step(c, cn, s, rs);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        coin_in = 0; cancel = 0; selection = 0; restock = 0;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        model_reset();
    endtask

    task automatic test_reset();
        coin_in = 0; cancel = 0; selection = 0; restock = 0; rst = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cur_state, credit, drink_out, refund, sold_out, insufficient, coin_reject} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got state=%0d credit=%0d drink=%0d refund=%0d flags=%b%b%b exp all 0",
                     cur_state, credit, drink_out, refund, sold_out, insufficient, coin_reject);
        end
        rst = 1;
        model_reset();
    endtask

    task automatic test_basic_vend();
        cyc(1, 0, 0, 0);
        n_checks++;
        if (cur_state !== 2'd1 || credit !== 4'd1) begin
            n_fail++; $display("FAIL basic_coin got state=%0d credit=%0d exp state=1 credit=1", cur_state, credit);
        end
        cyc(0, 0, 1, 0);
        n_checks++;
        if (cur_state !== 2'd2 || drink_out !== 2'd1 || refund !== 4'd0) begin
            n_fail++; $display("FAIL basic_vend got state=%0d drink=%0d refund=%0d exp 2/1/0", cur_state, drink_out, refund);
        end
        cyc(0, 0, 0, 0);
        n_checks++;
        if (cur_state !== 2'd0 || credit !== 4'd0 || drink_out !== 2'd0) begin
            n_fail++; $display("FAIL basic_idle got state=%0d credit=%0d drink=%0d exp 0/0/0", cur_state, credit, drink_out);
        end
    endtask

    task automatic test_insufficient_cancel();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 2, 0);
        n_checks++;
        if (insufficient !== 1'b1 || cur_state !== 2'd1 || credit !== 4'd1) begin
            n_fail++; $display("FAIL insufficient got insuf=%b state=%0d credit=%0d exp 1/1/1", insufficient, cur_state, credit);
        end
        cyc(0, 1, 0, 0);
        n_checks++;
        if (cur_state !== 2'd3 || refund !== 4'd1 || drink_out !== 2'd0) begin
            n_fail++; $display("FAIL cancel_refund got state=%0d refund=%0d drink=%0d exp 3/1/0", cur_state, refund, drink_out);
        end
        cyc(0, 0, 0, 0);
        n_checks++;
        if (cur_state !== 2'd0 || refund !== 4'd0) begin
            n_fail++; $display("FAIL cancel_idle got state=%0d refund=%0d exp 0/0", cur_state, refund);
        end
    endtask

    task automatic test_change_and_hold();
        for (int k = 0; k < 3; k++) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
        n_checks++;
        if (credit !== 4'd3) begin
            n_fail++; $display("FAIL three_coins got credit=%0d exp 3", credit);
        end
        cyc(0, 0, 2, 0);
        n_checks++;
        if (drink_out !== 2'd2 || refund !== 4'd1) begin
            n_fail++; $display("FAIL change got drink=%0d refund=%0d exp 2/1", drink_out, refund);
        end
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0);
        n_checks++;
        if (credit !== 4'd1 || cur_state !== 2'd1) begin
            n_fail++; $display("FAIL coin_held got credit=%0d state=%0d exp 1/1", credit, cur_state);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_sold_out_restock();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 1, 0);
            n_checks++;
            if (drink_out !== 2'd1) begin
                n_fail++; $display("FAIL stock_vend%0d got drink=%0d exp 1", k, drink_out);
            end
            cyc(0, 0, 0, 0);
        end
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        n_checks++;
        if (sold_out !== 1'b1 || credit !== 4'd1 || cur_state !== 2'd1) begin
            n_fail++; $display("FAIL sold_out got sold=%b credit=%0d state=%0d exp 1/1/1", sold_out, credit, cur_state);
        end
        cyc(0, 1, 0, 0);
        n_checks++;
        if (refund !== 4'd1) begin
            n_fail++; $display("FAIL sold_out_refund got refund=%0d exp 1", refund);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        n_checks++;
        if (drink_out !== 2'd1 || sold_out !== 1'b0) begin
            n_fail++; $display("FAIL restock_vend got drink=%0d sold=%b exp 1/0", drink_out, sold_out);
        end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 0, 0);
            if (k == 8) begin
                n_checks++;
                if (credit !== 4'd7 || coin_reject !== 1'b1) begin
                    n_fail++; $display("FAIL saturate got credit=%0d reject=%b exp 7/1", credit, coin_reject);
                end
            end
            cyc(0, 0, 0, 0);
        end
        cyc(1, 1, 0, 0);
        n_checks++;
        if (refund !== 4'd7 || coin_reject !== 1'b1 || cur_state !== 2'd3) begin
            n_fail++; $display("FAIL cancel_with_coin got refund=%0d reject=%b state=%0d exp 7/1/3", refund, coin_reject, cur_state);
        end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 0);
        n_checks++;
        if (drink_out !== 2'd1 || refund !== 4'd0 || coin_reject !== 1'b1) begin
            n_fail++; $display("FAIL vend_with_coin got drink=%0d refund=%0d reject=%b exp 1/0/1", drink_out, refund, coin_reject);
        end
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        n_checks++;
        if (cur_state !== 2'd1 || credit !== 4'd1) begin
            n_fail++; $display("FAIL next_txn got state=%0d credit=%0d exp 1/1", cur_state, credit);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
        #2 rst = 0;
        #1;
        n_checks++;
        if (cur_state !== 2'd0 || credit !== 4'd0 || refund !== 4'd0) begin
            n_fail++; $display("FAIL async_reset got state=%0d credit=%0d refund=%0d exp 0/0/0", cur_state, credit, refund);
        end
        @(posedge clk); #1;
        rst = 1;
        model_reset();
        cyc(0, 0, 0, 0);
        n_checks++;
        if (refund !== 4'd0 || cur_state !== 2'd0) begin
            n_fail++; $display("FAIL post_reset got refund=%0d state=%0d exp 0/0", refund, cur_state);
        end
    endtask

    task automatic test_random();
        int c, cn, s, rs;
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            c  = $urandom_range(0, 1);
            cn = ($urandom_range(0, 11) == 0);
            s  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            rs = ($urandom_range(0, 23) == 0);
            cyc(c, cn, s, rs);
            n_checks++;
            if (cur_state !== 2'(m_phase) || credit !== 4'(m_credit)) begin
                n_fail++; $display("FAIL rnd_state cyc=%0d got state=%0d credit=%0d exp %0d/%0d",
                                   n, cur_state, credit, m_phase, m_credit);
            end
            n_checks++;
            if (drink_out !== 2'(e_drink) || refund !== 4'(e_refund)) begin
                n_fail++; $display("FAIL rnd_vend cyc=%0d got drink=%0d refund=%0d exp %0d/%0d",
                                   n, drink_out, refund, e_drink, e_refund);
            end
            n_checks++;
            if ({sold_out, insufficient, coin_reject} !== {e_sold[0], e_insuf[0], e_rej[0]}) begin
                n_fail++; $display("FAIL rnd_flags cyc=%0d got sold/insuf/rej=%b%b%b exp %0d%0d%0d",
                                   n, sold_out, insufficient, coin_reject, e_sold, e_insuf, e_rej);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_vend();
        test_insufficient_cancel();
        test_change_and_hold();
        test_sold_out_restock();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vending_fsm_param.md
Name: vending_fsm_param

Overview:
Parametrised next-generation vending-machine controller. Supports N products with per-item prices and multi-coin credit, and returns change. Tracks per-item stock with sold-out refusal and restock. Sits between coin/keypad front-end logic and the dispense/refund actuators; cur_state is exported for debug and the bench.

Parameters:
NUM_ITEMS, 3, number of products; selection codes 1..NUM_ITEMS are valid, 0 means none; must be <= 2**SEL_W-1
SEL_W, 2, width of selection and drink_out
CREDIT_W, 4, width of credit, refund and price fields
MAX_CREDIT, 7, credit saturation limit in coins; must be <= 2**CREDIT_W-1
PRICES, 12'h321, packed prices; item k is at [(k-1)*CREDIT_W +: CREDIT_W]; default water=1, coke=2, juice=3
STOCK_W, 4, width of each per-item stock counter
STOCK_INIT, 5, stock loaded into every item on reset and on restock

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
coin_in  in  1  coin sensor; rising edge = one coin
cancel  in  1  cancel request, level sampled per cycle
selection  in  SEL_W  product request, 0 = none
restock  in  1  reload all stock counters; honoured in IDLE only
drink_out  out  SEL_W  dispensed item code; 1-cycle pulse, 0 otherwise
refund  out  CREDIT_W  coins returned; valid for 1 cycle, 0 otherwise
cur_state  out  2  IDLE=0, CREDIT=1, VEND=2, REFUND=3
credit  out  CREDIT_W  current accumulated credit
sold_out  out  1  1-cycle pulse: selected item has stock 0
insufficient  out  1  1-cycle pulse: credit < price of selected item
coin_reject  out  1  1-cycle pulse: coin edge not accepted

Behaviour:
- Reset (rst=0, async): state IDLE, credit=0, all stock=STOCK_INIT, all outputs 0, coin edge-detect register=0.
- Coin edge: coin_rise = coin_in & ~coin_q. Holding coin_in high counts once.
- IDLE: coin_rise sets credit=1 and moves to CREDIT. Selection and cancel are ignored. restock reloads stock, with no other effect.
- CREDIT, priority cancel > valid selection > coin:
  - cancel: refund<=credit, credit<=0, go to REFUND. A coin_rise in the same cycle raises coin_reject.
  - selection s, 1<=s<=NUM_ITEMS:
    - stock[s]==0: sold_out pulse; stay, credit kept.
    - credit<price[s]: insufficient pulse; stay.
    - otherwise: go to VEND, latch s and change=credit-price[s], credit<=0, stock[s]--. A concurrent coin_rise raises coin_reject.
  - A selection >NUM_ITEMS is ignored. A coin concurrent with a refused or ignored selection is accepted.
  - coin_rise: credit+1. If credit==MAX_CREDIT, coin_reject pulses instead and credit is unchanged.
  - restock is ignored in CREDIT.
- VEND (1 cycle): drink_out=s, refund=change, then IDLE. Coins in this state raise coin_reject.
- REFUND (1 cycle): refund=returned credit, drink_out=0, then IDLE. Coins in this state raise coin_reject.
- Outputs are registered: pulses appear the cycle after the triggering input is sampled.
- Price 0 is legal: the item vends on any credit >=1.
- Stock never underflows; it saturates at 0 and never exceeds STOCK_INIT.
- Reset mid-transaction discards credit with no refund pulse.

Optional Feature:
VEND_TIMEOUT_EN: adds parameter TIMEOUT_CYCLES (default 64) and an inactivity counter.
- The counter is cleared on entering CREDIT and on every coin_rise or nonzero selection.
- When it reaches TIMEOUT_CYCLES in CREDIT, the block behaves exactly as cancel: REFUND with the full credit.
- Undefined: no counter exists and CREDIT persists indefinitely.

Test Plan:
1. Reset, one coin pulse, selection=1 -> VEND cycle with drink_out=1, refund=0; then IDLE, credit=0.
2. One coin, selection=2 -> insufficient pulse, state CREDIT, credit=1. Then cancel -> REFUND with refund=1, drink_out=0; then IDLE.
3. Three coin pulses, selection=2 -> drink_out=2, refund=1. Separately, coin_in held high 3 cycles -> credit=1.
4. Vend item 1 five times (1 coin each). Sixth: coin + selection=1 -> sold_out pulse, credit=1 kept. Cancel (refund=1), restock in IDLE, coin + selection=1 -> drink_out=1.
5. Eight coin pulses -> credit=7, coin_reject on the 8th. cancel and coin_rise in the same cycle -> refund=7 and coin_reject.
6. Three coins, then rst=0 mid-CREDIT -> immediately cur_state=0, credit=0, refund stays 0. With VEND_TIMEOUT_EN: two coins, then idle 64 cycles -> refund=2.
